// File: rtl/univ_reg_n_if.sv
// Control, data and status bundle for the univ_reg_n universal register.
// The SCLR wire exists only when UNIV_REG_SCLR_EN is defined.
interface univ_reg_n_if #(
   parameter int WIDTH = 8
);
   logic             E;
   logic [2:0]       M;
   logic [WIDTH-1:0] D;
   logic             SIL;
   logic             SIR;
`ifdef UNIV_REG_SCLR_EN
   logic             SCLR;
`endif
   logic [WIDTH-1:0] Q;
   logic             SO;
   logic             TC;
   logic             Z;

`ifdef UNIV_REG_SCLR_EN
   modport master (output E, M, D, SIL, SIR, SCLR, input Q, SO, TC, Z);
   modport slave  (input E, M, D, SIL, SIR, SCLR, output Q, SO, TC, Z);
`else
   modport master (output E, M, D, SIL, SIR, input Q, SO, TC, Z);
   modport slave  (input E, M, D, SIL, SIR, output Q, SO, TC, Z);
`endif
endinterface

// File: rtl/univ_reg_n.sv
// Universal WIDTH-bit register: load, shift, rotate and up/down count with serial out and flags.
// Defining UNIV_REG_SCLR_EN adds a synchronous clear (SCLR) that has priority over E and M.
module univ_reg_n #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic         C,
   input logic         aRn,
   univ_reg_n_if.slave bus
);
   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROTL = 3'b100;
   localparam logic [2:0] MODE_ROTR = 3'b101;
   localparam logic [2:0] MODE_UP   = 3'b110;
   localparam logic [2:0] MODE_DOWN = 3'b111;

   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_next;
   logic             so;
   logic             so_next;
   logic             tc;
   logic             tc_next;
   logic             clear;

`ifdef UNIV_REG_SCLR_EN
   assign clear = bus.SCLR;
`else
   assign clear = 1'b0;
`endif

   // Next-state selection; TC only ever rises on the edge where the counter wraps.
   always_comb begin
      q_next  = q;
      so_next = so;
      tc_next = tc;
      if (clear) begin
         q_next  = RST_VAL;
         so_next = 1'b0;
         tc_next = 1'b0;
      end else if (bus.E) begin
         case (bus.M)
            MODE_HOLD: begin
               q_next = q;
            end
            MODE_LOAD: begin
               q_next  = bus.D;
               tc_next = 1'b0;
            end
            MODE_SHL: begin
               q_next  = {q[WIDTH-2:0], bus.SIL};
               so_next = q[WIDTH-1];
               tc_next = 1'b0;
            end
            MODE_SHR: begin
               q_next  = {bus.SIR, q[WIDTH-1:1]};
               so_next = q[0];
               tc_next = 1'b0;
            end
            MODE_ROTL: begin
               q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
               so_next = q[WIDTH-1];
               tc_next = 1'b0;
            end
            MODE_ROTR: begin
               q_next  = {q[0], q[WIDTH-1:1]};
               so_next = q[0];
               tc_next = 1'b0;
            end
            MODE_UP: begin
               q_next  = q + ONE;
               tc_next = (q == ALL_ONES);
            end
            MODE_DOWN: begin
               q_next  = q - ONE;
               tc_next = (q == ZERO);
            end
            default: begin
               q_next = q;
            end
         endcase
      end
   end

   always_ff @(posedge C or negedge aRn) begin
      if (!aRn) begin
         q  <= RST_VAL;
         so <= 1'b0;
         tc <= 1'b0;
      end else begin
         q  <= q_next;
         so <= so_next;
         tc <= tc_next;
      end
   end

   assign bus.Q  = q;
   assign bus.SO = so;
   assign bus.TC = tc;
   assign bus.Z  = (q == ZERO);
endmodule

// File: tb/tb_univ_reg_n.sv
// Directed bench for univ_reg_n (WIDTH=8, RST_VAL=A5) with an arithmetic reference model.
// Exercises the SCLR port as well when UNIV_REG_SCLR_EN is defined.
module tb_univ_reg_n;
   localparam int W   = 8;
   localparam int MOD = 256;
   localparam int HB  = MOD / 2;
   localparam int RV  = 'hA5;

   logic clk;
   logic rst_n;
   logic check_en;
   int   total;
   int   bad;

   int   m_q;
   int   m_so;
   int   m_tc;

   univ_reg_n_if #(.WIDTH(W)) bus ();

   univ_reg_n #(.WIDTH(W), .RST_VAL(8'hA5)) dut (
      .C   (clk),
      .aRn (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: register contents as a plain integer, modes as arithmetic on it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q  = RV;
         m_so = 0;
         m_tc = 0;
      end else begin
`ifdef UNIV_REG_SCLR_EN
         if (bus.SCLR === 1'b1) begin
            m_q  = RV;
            m_so = 0;
            m_tc = 0;
         end else
`endif
         if (bus.E) begin
            case (bus.M)
               3'd1: begin m_q = int'(bus.D); m_tc = 0; end
               3'd2: begin m_so = m_q / HB; m_q = (m_q * 2 + int'(bus.SIL)) % MOD; m_tc = 0; end
               3'd3: begin m_so = m_q % 2; m_q = m_q / 2 + int'(bus.SIR) * HB; m_tc = 0; end
               3'd4: begin m_so = m_q / HB; m_q = (m_q * 2 + m_so) % MOD; m_tc = 0; end
               3'd5: begin m_so = m_q % 2; m_q = m_q / 2 + m_so * HB; m_tc = 0; end
               3'd6: begin m_tc = (m_q == MOD - 1) ? 1 : 0; m_q = (m_q + 1) % MOD; end
               3'd7: begin m_tc = (m_q == 0) ? 1 : 0; m_q = (m_q + MOD - 1) % MOD; end
               default: ;
            endcase
         end
      end
   end

   task automatic checkValue(input string name, input logic [31:0] got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   // Every falling edge: DUT must agree with the model.
   always @(negedge clk) begin
      if (check_en) begin
         checkValue("cyc_q",  {24'b0, bus.Q},  m_q);
         checkValue("cyc_so", {31'b0, bus.SO}, m_so);
         checkValue("cyc_tc", {31'b0, bus.TC}, m_tc);
         checkValue("cyc_z",  {31'b0, bus.Z},  (m_q == 0) ? 1 : 0);
      end
   end

   task automatic checkOutput(input string name, input int q, input int so, input int tc, input int z);
      checkValue({name, "_q"},  {24'b0, bus.Q},  q);
      checkValue({name, "_so"}, {31'b0, bus.SO}, so);
      checkValue({name, "_tc"}, {31'b0, bus.TC}, tc);
      checkValue({name, "_z"},  {31'b0, bus.Z},  z);
   endtask

   // Called just after a falling edge; returns at the next falling edge.
   task automatic applyStimulus(input logic e, input logic [2:0] m, input logic [7:0] d,
                                input logic sil, input logic sir);
      bus.E   = e;
      bus.M   = m;
      bus.D   = d;
      bus.SIL = sil;
      bus.SIR = sir;
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic       e;
      logic [2:0] m;
      logic [7:0] d;
      logic       sil;
      logic       sir;
   } vec_t;

   vec_t mix[10];
   int   pulses;

   initial begin
      total    = 0;
      bad      = 0;
      check_en = 1'b0;
      rst_n    = 1'b1;
      bus.E    = 1'b0;
      bus.M    = 3'b000;
      bus.D    = 8'h00;
      bus.SIL  = 1'b0;
      bus.SIR  = 1'b0;
`ifdef UNIV_REG_SCLR_EN
      bus.SCLR = 1'b0;
`endif
      #1 rst_n = 1'b0;
      #2 checkOutput("reset", 'hA5, 0, 0, 0);
      @(negedge clk);
      rst_n    = 1'b1;
      check_en = 1'b1;

      applyStimulus(1, 3'b001, 8'h3C, 0, 0); checkOutput("load", 'h3C, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 3'b010, 8'hFF, 1, 1); checkOutput("hold_e0", 'h3C, 0, 0, 0);
      end
      applyStimulus(1, 3'b000, 8'hFF, 1, 1); checkOutput("hold_m0", 'h3C, 0, 0, 0);

      applyStimulus(1, 3'b001, 8'h81, 0, 0); checkOutput("load81", 'h81, 0, 0, 0);
      applyStimulus(1, 3'b010, 8'h00, 0, 0); checkOutput("shl", 'h02, 1, 0, 0);
      applyStimulus(1, 3'b011, 8'h00, 0, 1); checkOutput("shr", 'h81, 0, 0, 0);

      applyStimulus(1, 3'b100, 8'h00, 0, 0); checkOutput("rotl", 'h03, 1, 0, 0);
      applyStimulus(1, 3'b001, 8'h81, 0, 0);
      applyStimulus(1, 3'b101, 8'h00, 0, 0); checkOutput("rotr1", 'hC0, 1, 0, 0);
      applyStimulus(1, 3'b101, 8'h00, 0, 0); checkOutput("rotr2", 'h60, 0, 0, 0);
      applyStimulus(1, 3'b001, 8'h81, 0, 0);
      applyStimulus(1, 3'b100, 8'h00, 0, 0);
      applyStimulus(1, 3'b101, 8'h00, 0, 0); checkOutput("rotr_a", 'h81, 1, 0, 0);
      applyStimulus(1, 3'b101, 8'h00, 0, 0); checkOutput("rotr_b", 'hC0, 1, 0, 0);

      applyStimulus(1, 3'b001, 8'hFE, 0, 0); checkOutput("loadFE", 'hFE, 1, 0, 0);
      applyStimulus(1, 3'b110, 8'h00, 0, 0); checkOutput("up1", 'hFF, 1, 0, 0);
      applyStimulus(1, 3'b110, 8'h00, 0, 0); checkOutput("up2", 'h00, 1, 1, 1);
      applyStimulus(0, 3'b110, 8'h00, 0, 0); checkOutput("tc_hold", 'h00, 1, 1, 1);
      applyStimulus(1, 3'b110, 8'h00, 0, 0); checkOutput("up3", 'h01, 1, 0, 0);
      applyStimulus(1, 3'b111, 8'h00, 0, 0); checkOutput("dn1", 'h00, 1, 0, 1);
      applyStimulus(1, 3'b111, 8'h00, 0, 0); checkOutput("dn2", 'hFF, 1, 1, 0);

      // Asynchronous reset pulse entirely between two rising edges.
      #2 rst_n = 1'b0;
      #1 checkOutput("areset", 'hA5, 0, 0, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("after_areset", 'hA4, 0, 0, 0);

      // Reset while counting up, held low across a rising edge.
      applyStimulus(1, 3'b001, 8'h7E, 0, 0);
      applyStimulus(1, 3'b110, 8'h00, 0, 0); checkOutput("cnt7F", 'h7F, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1 checkOutput("mid_rst", 'hA5, 0, 0, 0);
      @(posedge clk);
      #1 checkOutput("rst_edge", 'hA5, 0, 0, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("released", 'hA5, 0, 0, 0);
      applyStimulus(1, 3'b110, 8'h00, 0, 0); checkOutput("resume", 'hA6, 0, 0, 0);

      mix[0] = '{1, 3'b001, 8'h5A, 0, 0};
      mix[1] = '{1, 3'b010, 8'h00, 1, 0};
      mix[2] = '{1, 3'b010, 8'h00, 1, 0};
      mix[3] = '{1, 3'b011, 8'h00, 0, 0};
      mix[4] = '{1, 3'b011, 8'h00, 0, 1};
      mix[5] = '{0, 3'b001, 8'h11, 0, 0};
      mix[6] = '{1, 3'b100, 8'h00, 0, 0};
      mix[7] = '{1, 3'b101, 8'h00, 0, 0};
      mix[8] = '{1, 3'b001, 8'h00, 0, 0};
      mix[9] = '{1, 3'b111, 8'h00, 0, 0};
      foreach (mix[i]) applyStimulus(mix[i].e, mix[i].m, mix[i].d, mix[i].sil, mix[i].sir);
      checkOutput("mix_end", 'hFF, 1, 1, 0);

      // One full up-count period must produce exactly one TC pulse.
      applyStimulus(1, 3'b001, 8'h00, 0, 0);
      pulses = 0;
      for (int i = 0; i < MOD; i++) begin
         applyStimulus(1, 3'b110, 8'h00, 0, 0);
         if (bus.TC === 1'b1) pulses++;
      end
      checkValue("tc_period", pulses, 1);
      checkOutput("period_end", 'h00, 1, 1, 1);

`ifdef UNIV_REG_SCLR_EN
      applyStimulus(1, 3'b001, 8'h55, 0, 0);
      bus.SCLR = 1'b1;
      applyStimulus(1, 3'b110, 8'h00, 0, 0); checkOutput("sclr", 'hA5, 0, 0, 0);
      bus.SCLR = 1'b0;
      applyStimulus(1, 3'b110, 8'h00, 0, 0); checkOutput("post_sclr", 'hA6, 0, 0, 0);
`endif

      applyStimulus(0, 3'b000, 8'h00, 0, 0);
      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/univ_reg_n.md
Name: univ_reg_n

Overview:
- Parametrised universal register, successor to the fixed 4-bit load register.
- Generalised to WIDTH bits; adds shift, rotate and up/down count modes, serial in/out, and status flags.
- Used as the general storage/shift/count element in datapaths on the EP4CE6 board designs.
- Single clock domain.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RST_VAL, 0, value Q takes on reset (WIDTH bits, truncated).

Ports:
- C  input  1  clock, rising edge active.
- aRn  input  1  asynchronous reset, active-low; forces Q=RST_VAL and all flags to reset values.
- E  input  1  operation enable; 0 = hold regardless of M.
- M  input  3  mode select (see Behaviour).
- D  input  WIDTH  parallel load data.
- SIL  input  1  serial input entering at the LSB on shift left.
- SIR  input  1  serial input entering at the MSB on shift right.
- Q  output  WIDTH  register contents.
- SO  output  1  serial out; bit shifted out by the last shift operation.
- TC  output  1  terminal count / carry, registered.
- Z  output  1  combinational, 1 when Q == 0.

Behaviour:
- Interface: one clock C; reset aRn is asynchronous, active-low.
- aRn low, at any time (including mid-operation): Q=RST_VAL, SO=0, TC=0 immediately, independent of C. While aRn is low, clock edges have no effect.
- After aRn deasserts, the first rising edge of C operates normally. No synchronous recovery delay is required of the block.
- All updates occur at the rising edge of C. Latency is 1 cycle from input sampling to Q.
- E=0: Q, SO and TC all hold.
- E=1, by mode M:
  - 000 hold: Q, SO, TC hold.
  - 001 load: Q<=D; SO hold; TC<=0.
  - 010 shl: Q<={Q[W-2:0],SIL}; SO<=Q[W-1]; TC<=0.
  - 011 shr: Q<={SIR,Q[W-1:1]}; SO<=Q[0]; TC<=0.
  - 100 rotl: Q<={Q[W-2:0],Q[W-1]}; SO<=Q[W-1]; TC<=0.
  - 101 rotr: Q<={Q[0],Q[W-1:1]}; SO<=Q[0]; TC<=0.
  - 110 up: Q<=Q+1, modulo 2^WIDTH; TC<=1 only on the edge where Q wraps from all-ones to 0, else 0; SO hold.
  - 111 down: Q<=Q-1, modulo 2^WIDTH; TC<=1 only on the edge where Q wraps from 0 to all-ones, else 0; SO hold.
- TC is a one-cycle pulse per wrap. In continuous up-counting it re-asserts every 2^WIDTH cycles.
- Z is derived combinationally from Q: Z=1 during reset when RST_VAL==0.
- M and D are sampled only at the clock edge. Changes between edges have no effect.
- If M or D is X/undefined while E=1, the result is unspecified. The bench shall not drive this case.

Optional Feature:
- Macro: UNIV_REG_SCLR_EN.
- Defined: adds input port SCLR (1 bit).
  - SCLR=1 at a rising edge gives Q<=RST_VAL, SO<=0, TC<=0.
  - SCLR has priority over E and M, but not over aRn.
- Undefined: no SCLR port; behaviour exactly as above.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5; pulse aRn low between clock edges -> Q=A5, SO=0, TC=0 immediately, without waiting for an edge.
- Load/hold: E=1, M=001, D=3C, then E=0 with M=010 for 3 cycles -> Q=3C throughout the hold cycles.
- Shift: Q=81, M=010, SIL=0 -> Q=02, SO=1. Then M=011, SIR=1 -> Q=81, SO=0.
- Rotate: Q=81, M=100 -> Q=03, SO=1. Then M=101 twice -> Q=C0 after the second rotr, SO=1.
- Count wrap: Q=FE, M=110 for 3 edges -> Q=FF,00,01; TC=0,1,0; Z=1 only while Q=00. Then M=111 from 00 -> Q=FF, TC=1.
- Reset mid-count: counting up at Q=7F, aRn low for half a cycle -> Q=RST_VAL asynchronously, TC=0. Counting resumes from RST_VAL on the first edge after release. With UNIV_REG_SCLR_EN defined: SCLR=1 with M=110 -> Q=RST_VAL.
